mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the MIPS core. It sequences the shared datapath (ifu, gpr, alu, dm) through fetch, decode, execute, memory and write-back steps, one instruction at a time.
- Replaces per-instruction combinational control so that the alu and the memory port are reused across cycles.
- Also keeps retired-instruction and cycle counters for the testbench to probe.

Parameters:
- CNT_W, 32, width of the instr_cnt and cyc_cnt counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- op  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- zero  in  1  alu zero flag.
- pc_wr  out  1  PC write enable.
- ir_wr  out  1  IR write enable.
- reg_wr  out  1  gpr write enable.
- mem_wr  out  1  data memory write enable.
- alu_src  out  1  alu B operand select: 0 = rt, 1 = extended immediate.
- alu_op  out  3  000 add, 001 sub, 010 or, 011 pass B.
- ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16.
- reg_dst  out  2  00 rt, 01 rd, 10 $31.
- mem_to_reg  out  2  00 alu, 01 mem, 10 pc+4.
- npc_sel  out  2  00 pc+4, 01 branch target, 10 jump target, 11 rs.
- state  out  4  current state, for debug.
- illegal  out  1  1-cycle pulse on an undecodable instruction.
- instr_cnt  out  CNT_W  retired instructions.
- cyc_cnt  out  CNT_W  cycles since reset.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, ALUWB=7, BRANCH=8, JUMP=9.
- rst low, asynchronous:
  - state=FETCH, counters=0, illegal=0.
  - All enables (pc_wr, ir_wr, reg_wr, mem_wr) forced to 0 while rst is low.
  - Selects take their FETCH values.
- Outputs are Moore, decoded from state plus op/funct. Exception: pc_wr in BRANCH equals zero.
- Default for every output in every state is 0 unless listed below.
- FETCH: ir_wr=1, pc_wr=1, npc_sel=00. Next state DECODE.
- DECODE (decodes op/funct):
  - R-type with funct addu(100001) or subu(100011) -> EXEC.
  - R-type with funct jr(001000) -> JUMP.
  - ori(001101) -> EXEC.
  - lui(001111) -> EXEC.
  - lw(100011) -> MEMADR.
  - sw(101011) -> MEMADR.
  - beq(000100) -> BRANCH.
  - j(000010) -> JUMP.
  - jal(000011) -> JUMP.
  - Anything else -> FETCH with illegal=1 for one cycle.
- EXEC: alu_op is addu 000, subu 001, ori 010 with alu_src=1 and ext_op=00, lui 011 with alu_src=1 and ext_op=10. Next state ALUWB.
- ALUWB: reg_wr=1. reg_dst=01 for R-type, 00 otherwise. mem_to_reg=00. Same alu_op/alu_src/ext_op as EXEC. Next state FETCH.
- MEMADR: alu_op=000, alu_src=1, ext_op=01. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: hold MEMADR selects; address registered. Next state MEMWB.
- MEMWB: reg_wr=1, reg_dst=00, mem_to_reg=01. Next state FETCH.
- MEMWR: mem_wr=1, plus MEMADR selects. Next state FETCH.
- BRANCH: alu_op=001, alu_src=0, ext_op=01, npc_sel=01, pc_wr=zero. Next state FETCH.
- JUMP:
  - j: npc_sel=10, pc_wr=1.
  - jal: additionally reg_wr=1, reg_dst=10, mem_to_reg=10.
  - jr: npc_sel=11, pc_wr=1.
  - Next state FETCH.
- instr_cnt increments on every transition into FETCH from a completing state (ALUWB, MEMWB, MEMWR, BRANCH, JUMP). It does not increment on the illegal path.
- cyc_cnt increments every cycle rst is high.
- Both counters wrap modulo 2^CNT_W.
- Latency per instruction:
  - R-type / ori / lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, j, jal, jr: 3 cycles.
  - Illegal: 2 cycles.
- Unused state encodings (10–15) go to FETCH on the next edge with all enables 0.
- Reset asserted mid-instruction aborts it: no write enable is asserted after rst falls, and the partial instruction is not counted.

Decomposition:
- Package mips_defs holds:
  - opcode and funct constants;
  - state encodings;
  - alu_op, ext_op, reg_dst, mem_to_reg and npc_sel codes.
- One sub-module, mc_ctrl_dec: purely combinational op/funct -> instruction class (RTYPE_ALU, ORI, LUI, LW, SW, BEQ, J, JAL, JR, ILLEGAL). It is shared by the next-state and output logic.

Test Plan:
- Reset: drive rst=0 at an arbitrary state -> state=0, pc_wr=ir_wr=reg_wr=mem_wr=0, instr_cnt=cyc_cnt=0. After release, first cycle ir_wr=1, pc_wr=1.
- addu (op=0, funct=0x21) -> states 0,1,2,7. reg_wr=1 with reg_dst=01 only in cycle 4. instr_cnt=1 after 4 cycles.
- lw (op=0x23) then sw (op=0x2B) -> states 0,1,3,4,5 then 0,1,3,6. mem_wr=1 exactly once. reg_wr=1 exactly once. instr_cnt=2 after 9 cycles.
- beq with zero=1, then beq with zero=0 -> pc_wr=1 in the first BRANCH cycle, 0 in the second. npc_sel=01 in both.
- jal (op=3) -> JUMP with reg_wr=1, reg_dst=10, mem_to_reg=10, npc_sel=10. jr (op=0, funct=0x08) -> npc_sel=11, reg_wr=0.
- op=0x3F -> DECODE returns to FETCH, illegal high for exactly 1 cycle, instr_cnt unchanged, cyc_cnt +2.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared MIPS encodings for the multi-cycle controller: opcodes, funct codes,
// FSM states, datapath select codes and the decoded instruction classes.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE_ALU,
        C_ORI,
        C_LUI,
        C_LW,
        C_SW,
        C_BEQ,
        C_J,
        C_JAL,
        C_JR,
        C_ILLEGAL
    } instr_class_t;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_PASSB = 3'b011;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_HI16  = 2'b10;

    localparam logic [1:0] DST_RT    = 2'b00;
    localparam logic [1:0] DST_RD    = 2'b01;
    localparam logic [1:0] DST_RA    = 2'b10;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_PC4    = 2'b10;

    localparam logic [1:0] NPC_PC4   = 2'b00;
    localparam logic [1:0] NPC_BR    = 2'b01;
    localparam logic [1:0] NPC_JMP   = 2'b10;
    localparam logic [1:0] NPC_RS    = 2'b11;

    // States whose exit retires an instruction.
    function automatic logic is_retire_state(input state_t s);
        return (s == S_ALUWB) || (s == S_MEMWB) || (s == S_MEMWR) ||
               (s == S_BRANCH) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and alu flag in, enables/selects,
// debug state and performance counters out.
interface mc_ctrl_if #(parameter int CNT_W = 32);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             pc_wr;
    logic             ir_wr;
    logic             reg_wr;
    logic             mem_wr;
    logic             alu_src;
    logic [2:0]       alu_op;
    logic [1:0]       ext_op;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic [1:0]       npc_sel;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] cyc_cnt;

    modport master (
        input  op, funct, zero,
        output pc_wr, ir_wr, reg_wr, mem_wr, alu_src, alu_op, ext_op,
               reg_dst, mem_to_reg, npc_sel, state, illegal, instr_cnt, cyc_cnt
    );

    modport slave (
        output op, funct, zero,
        input  pc_wr, ir_wr, reg_wr, mem_wr, alu_src, alu_op, ext_op,
               reg_dst, mem_to_reg, npc_sel, state, illegal, instr_cnt, cyc_cnt
    );
endinterface

// File: rtl/mc_ctrl_dec.sv
// Pure combinational op/funct -> instruction class; shared by next-state and
// output decoding so both always agree on what the instruction is.
module mc_ctrl_dec
    import mips_defs::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    output instr_class_t cls
);
    always_comb begin
        cls = C_ILLEGAL;
        unique case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU) cls = C_RTYPE_ALU;
                else if (funct == FN_JR)                  cls = C_JR;
                else                                      cls = C_ILLEGAL;
            end
            OP_ORI:  cls = C_ORI;
            OP_LUI:  cls = C_LUI;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  cls = C_BEQ;
            OP_J:    cls = C_J;
            OP_JAL:  cls = C_JAL;
            default: cls = C_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: one instruction at a time, 2-5 cycles each.
// Moore outputs from state + IR fields; enables are held low during reset.
module mc_ctrl
    import mips_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    mc_ctrl_if.master  bus
);
    state_t           cur_state;
    state_t           nxt_state;
    instr_class_t     cls;
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] cyc_cnt;

    logic       pc_wr_c, ir_wr_c, reg_wr_c, mem_wr_c, illegal_c, alu_src_c;
    logic [2:0] alu_op_c;
    logic [1:0] ext_op_c, reg_dst_c, mem_to_reg_c, npc_sel_c;

    mc_ctrl_dec u_dec (
        .op    (bus.op),
        .funct (bus.funct),
        .cls   (cls)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur_state <= S_FETCH;
        else      cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:  nxt_state = S_DECODE;
            S_DECODE: begin
                case (cls)
                    C_RTYPE_ALU, C_ORI, C_LUI:  nxt_state = S_EXEC;
                    C_LW, C_SW:                 nxt_state = S_MEMADR;
                    C_BEQ:                      nxt_state = S_BRANCH;
                    C_J, C_JAL, C_JR:           nxt_state = S_JUMP;
                    default:                    nxt_state = S_FETCH;
                endcase
            end
            S_EXEC:   nxt_state = S_ALUWB;
            S_MEMADR: nxt_state = (cls == C_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  nxt_state = S_MEMWB;
            default:  nxt_state = S_FETCH;
        endcase
    end

    always_comb begin
        pc_wr_c      = 1'b0;
        ir_wr_c      = 1'b0;
        reg_wr_c     = 1'b0;
        mem_wr_c     = 1'b0;
        illegal_c    = 1'b0;
        alu_src_c    = 1'b0;
        alu_op_c     = ALU_ADD;
        ext_op_c     = EXT_ZERO;
        reg_dst_c    = DST_RT;
        mem_to_reg_c = WB_ALU;
        npc_sel_c    = NPC_PC4;
        case (cur_state)
            S_FETCH: begin
                ir_wr_c   = 1'b1;
                pc_wr_c   = 1'b1;
                npc_sel_c = NPC_PC4;
            end
            S_DECODE: illegal_c = (cls == C_ILLEGAL);
            // ALUWB keeps the EXEC operand selects so the alu result stays stable.
            S_EXEC, S_ALUWB: begin
                case (cls)
                    C_RTYPE_ALU: alu_op_c = (bus.funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
                    C_ORI: begin
                        alu_op_c  = ALU_OR;
                        alu_src_c = 1'b1;
                        ext_op_c  = EXT_ZERO;
                    end
                    C_LUI: begin
                        alu_op_c  = ALU_PASSB;
                        alu_src_c = 1'b1;
                        ext_op_c  = EXT_HI16;
                    end
                    default: ;
                endcase
                if (cur_state == S_ALUWB) begin
                    reg_wr_c     = 1'b1;
                    reg_dst_c    = (cls == C_RTYPE_ALU) ? DST_RD : DST_RT;
                    mem_to_reg_c = WB_ALU;
                end
            end
            S_MEMADR, S_MEMRD, S_MEMWR: begin
                alu_op_c  = ALU_ADD;
                alu_src_c = 1'b1;
                ext_op_c  = EXT_SIGN;
                mem_wr_c  = (cur_state == S_MEMWR);
            end
            S_MEMWB: begin
                reg_wr_c     = 1'b1;
                reg_dst_c    = DST_RT;
                mem_to_reg_c = WB_MEM;
            end
            S_BRANCH: begin
                alu_op_c  = ALU_SUB;
                alu_src_c = 1'b0;
                ext_op_c  = EXT_SIGN;
                npc_sel_c = NPC_BR;
                pc_wr_c   = bus.zero;
            end
            S_JUMP: begin
                pc_wr_c = 1'b1;
                case (cls)
                    C_JR:  npc_sel_c = NPC_RS;
                    C_JAL: begin
                        npc_sel_c    = NPC_JMP;
                        reg_wr_c     = 1'b1;
                        reg_dst_c    = DST_RA;
                        mem_to_reg_c = WB_PC4;
                    end
                    default: npc_sel_c = NPC_JMP;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_cnt <= '0;
            cyc_cnt   <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (is_retire_state(cur_state)) instr_cnt <= instr_cnt + 1'b1;
        end
    end

    // FETCH asserts enables, so they must be explicitly masked while in reset.
    assign bus.pc_wr      = rst & pc_wr_c;
    assign bus.ir_wr      = rst & ir_wr_c;
    assign bus.reg_wr     = rst & reg_wr_c;
    assign bus.mem_wr     = rst & mem_wr_c;
    assign bus.illegal    = rst & illegal_c;
    assign bus.alu_src    = alu_src_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.ext_op     = ext_op_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.npc_sel    = npc_sel_c;
    assign bus.state      = cur_state;
    assign bus.instr_cnt  = instr_cnt;
    assign bus.cyc_cnt    = cyc_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: each instruction expands into a per-cycle list of
// expected control words, compared every cycle along with both counters.
module tb_mc_ctrl;
    localparam int CNT_W = 32;

    typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW,
                      K_BEQ, K_J, K_JAL, K_ILL} kind_t;

    typedef struct {
        int st;
        bit pc_wr, ir_wr, reg_wr, mem_wr, alu_src, ill, pc_is_zero;
        int alu_op, ext_op, reg_dst, m2r, npc;
    } step_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   m_cyc;
    int   m_inst;

    mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: return (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU :
                          (fn == 6'h08) ? K_JR : K_ILL;
            6'h0D: return K_ORI;
            6'h0F: return K_LUI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic step_t blank(input int st);
        step_t s;
        s = '{st: st, default: 0};
        return s;
    endfunction

    // Expected cycle-by-cycle control words for one whole instruction.
    function automatic void build(input kind_t k, ref step_t q[$]);
        step_t s;
        q.delete();
        s = blank(0); s.pc_wr = 1; s.ir_wr = 1; q.push_back(s);
        s = blank(1); s.ill = (k == K_ILL); q.push_back(s);
        case (k)
            K_ADDU, K_SUBU, K_ORI, K_LUI: begin
                s = blank(2);
                s.alu_op  = (k == K_SUBU) ? 1 : (k == K_ORI) ? 2 : (k == K_LUI) ? 3 : 0;
                s.alu_src = (k == K_ORI || k == K_LUI);
                s.ext_op  = (k == K_LUI) ? 2 : 0;
                q.push_back(s);
                s.st = 7; s.reg_wr = 1;
                s.reg_dst = (k == K_ADDU || k == K_SUBU) ? 1 : 0;
                q.push_back(s);
            end
            K_LW, K_SW: begin
                s = blank(3); s.alu_src = 1; s.ext_op = 1; q.push_back(s);
                if (k == K_LW) begin
                    s.st = 4; q.push_back(s);
                    s = blank(5); s.reg_wr = 1; s.m2r = 1; q.push_back(s);
                end else begin
                    s.st = 6; s.mem_wr = 1; q.push_back(s);
                end
            end
            K_BEQ: begin
                s = blank(8); s.alu_op = 1; s.ext_op = 1; s.npc = 1; s.pc_is_zero = 1;
                q.push_back(s);
            end
            K_J, K_JAL, K_JR: begin
                s = blank(9); s.pc_wr = 1; s.npc = (k == K_JR) ? 3 : 2;
                if (k == K_JAL) begin s.reg_wr = 1; s.reg_dst = 2; s.m2r = 2; end
                q.push_back(s);
            end
            default: ;
        endcase
    endfunction

    // Called at a negedge with the DUT expected in FETCH.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
        step_t q[$];
        kind_t k;
        logic  z;
        k = classify(op, fn);
        build(k, q);
        bus.op = op;
        bus.funct = fn;
        foreach (q[i]) begin
            z = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            bus.zero = z;
            #1;
            check("state",      32'(bus.state),      32'(q[i].st));
            check("pc_wr",      32'(bus.pc_wr),      q[i].pc_is_zero ? 32'(z) : 32'(q[i].pc_wr));
            check("ir_wr",      32'(bus.ir_wr),      32'(q[i].ir_wr));
            check("reg_wr",     32'(bus.reg_wr),     32'(q[i].reg_wr));
            check("mem_wr",     32'(bus.mem_wr),     32'(q[i].mem_wr));
            check("alu_src",    32'(bus.alu_src),    32'(q[i].alu_src));
            check("alu_op",     32'(bus.alu_op),     32'(q[i].alu_op));
            check("ext_op",     32'(bus.ext_op),     32'(q[i].ext_op));
            check("reg_dst",    32'(bus.reg_dst),    32'(q[i].reg_dst));
            check("mem_to_reg", 32'(bus.mem_to_reg), 32'(q[i].m2r));
            check("npc_sel",    32'(bus.npc_sel),    32'(q[i].npc));
            check("illegal",    32'(bus.illegal),    32'(q[i].ill));
            check("instr_cnt",  bus.instr_cnt,       32'(m_inst));
            check("cyc_cnt",    bus.cyc_cnt,         32'(m_cyc));
            @(negedge clk);
            m_cyc++;
        end
        if (k != K_ILL) m_inst++;
    endtask

    task automatic check_in_reset(input string tag);
        check({tag, "_state"},  32'(bus.state),  32'd0);
        check({tag, "_pc_wr"},  32'(bus.pc_wr),  32'd0);
        check({tag, "_ir_wr"},  32'(bus.ir_wr),  32'd0);
        check({tag, "_reg_wr"}, 32'(bus.reg_wr), 32'd0);
        check({tag, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
        check({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
        check({tag, "_instr"},  bus.instr_cnt,   32'd0);
        check({tag, "_cyc"},    bus.cyc_cnt,     32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        m_cyc = 0;
        m_inst = 0;
    endtask

    task automatic random_instr();
        logic [5:0] op, fn;
        int r;
        r  = $urandom_range(0, 11);
        op = 6'($urandom);
        fn = 6'($urandom);
        case (r)
            0: begin op = 6'h00; fn = 6'h21; end
            1: begin op = 6'h00; fn = 6'h23; end
            2: begin op = 6'h00; fn = 6'h08; end
            3: op = 6'h0D;
            4: op = 6'h0F;
            5: op = 6'h23;
            6: op = 6'h2B;
            7: op = 6'h04;
            8: op = 6'h02;
            9: op = 6'h03;
            10: while (classify(op, fn) != K_ILL) op = 6'($urandom);
            default: begin
                op = 6'h00;
                while (classify(op, fn) != K_ILL) fn = 6'($urandom);
            end
        endcase
        run_instr(op, fn, -1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        bus.op = 6'h00;
        bus.funct = 6'h00;
        bus.zero = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_in_reset("por");
        release_reset();

        run_instr(6'h00, 6'h21, -1);   // addu
        run_instr(6'h23, 6'h00, -1);   // lw
        run_instr(6'h2B, 6'h00, -1);   // sw
        run_instr(6'h04, 6'h00, 1);    // beq taken
        run_instr(6'h04, 6'h00, 0);    // beq not taken
        run_instr(6'h03, 6'h00, -1);   // jal
        run_instr(6'h00, 6'h08, -1);   // jr
        run_instr(6'h3F, 6'h00, -1);   // illegal op
        run_instr(6'h00, 6'h23, -1);   // subu
        run_instr(6'h0D, 6'h00, -1);   // ori
        run_instr(6'h0F, 6'h00, -1);   // lui
        run_instr(6'h02, 6'h00, -1);   // j

        for (int i = 0; i < 300; i++) random_instr();

        // Abort a lw mid-flight: reset lands while in MEMADR.
        bus.op = 6'h23;
        bus.funct = 6'h00;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_in_reset("abort");
        repeat (2) @(negedge clk);
        #1 check_in_reset("held");
        release_reset();
        run_instr(6'h00, 6'h21, -1);
        run_instr(6'h2B, 6'h00, -1);
        #1 check("post_abort_instr", bus.instr_cnt, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
